// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the audio byte packers and the host-side
// decoder.
//   packer_state_t      - frame emitter FSM states
//   SYNC_WORD_DEFAULT   - sync pattern the host decoder searches for
//   BYTE_ORDER_LSB_FIRST - frames go out least-significant byte first
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        SYNC = 2'd2
    } packer_state_t;

    localparam logic [23:0] SYNC_WORD_DEFAULT    = 24'hAAFF00;
    localparam bit          BYTE_ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sample_queue.sv
// sample_queue: 2-entry synchronous FIFO.
//   clk, rst_n    - clock, synchronous active-low reset
//   push_i/data_i - write request and data; ignored when full unless popping
//                   on the same edge
//   pop_i         - read request; ignored when empty
//   data_o        - head entry (valid when !empty_o)
//   full_o/empty_o/count_o - occupancy
module sample_queue #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot on the same edge, so a full queue may still push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sample_byte_packer.sv
// sample_byte_packer: serialises PCM samples into an 8-bit FIFO as
// fixed-size little-endian frames, with a sync frame after every
// SYNC_PERIOD data frames (and first after reset).
//   clk, rst_n     - clock, synchronous active-low reset
//   sample_valid   - one-cycle strobe for sample_data
//   sample_data    - PCM sample, top 8*BYTES_PER_SAMPLE bits are sent
//   fifo_full      - downstream FIFO full; stalls the current frame
//   fifo_wr_en     - byte write strobe
//   fifo_wr_data   - byte to write
//   sample_dropped - pulse when a sample arrives with the queue full
//   drop_count     - saturating count of dropped samples
//   busy           - frame in flight or samples queued
module sample_byte_packer
    import audio_pkg::*;
#(
    parameter int          DATA_SIZE        = 24,
    parameter int          BYTES_PER_SAMPLE = 3,
    parameter int          SYNC_PERIOD      = 126,
    parameter logic [23:0] SYNC_WORD        = SYNC_WORD_DEFAULT,
    parameter int          DROP_CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [DATA_SIZE-1:0]  sample_data,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [7:0]            fifo_wr_data,
    output logic                  sample_dropped,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy
);

    localparam int FW    = 8 * BYTES_PER_SAMPLE;
    localparam int CNT_W = $clog2(SYNC_PERIOD + 1);

    packer_state_t         state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [FW-1:0]         sh_q, sh_d;
    logic [CNT_W-1:0]      sync_cnt_q, sync_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  dropped_q, busy_q, busy_d;

    logic                  q_push, q_pop, q_full, q_empty;
    logic [DATA_SIZE-1:0]  q_data;
    logic [1:0]            q_count, q_count_nxt;
    logic                  sync_due, wr, last_byte, drop;

    sample_queue #(.W(DATA_SIZE)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .data_i  (sample_data),
        .pop_i   (q_pop),
        .data_o  (q_data),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign sync_due  = (sync_cnt_q == CNT_W'(SYNC_PERIOD));
    // Sync has priority, so the queue is only popped on a data decision.
    assign q_pop     = (state_q == IDLE) && !sync_due && !q_empty;
    assign q_push    = sample_valid && (!q_full || q_pop);
    assign drop      = sample_valid && q_full && !q_pop;
    assign wr        = (state_q != IDLE) && !fifo_full;
    assign last_byte = (idx_q == 2'(BYTES_PER_SAMPLE - 1));

    // Gated by rst_n so an abandoned frame never writes during reset.
    assign fifo_wr_en     = wr && rst_n;
    assign fifo_wr_data   = sh_q[7:0];
    assign sample_dropped = dropped_q;
    assign drop_count     = drop_cnt_q;
    assign busy           = busy_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        sync_cnt_d = sync_cnt_q;
        case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                if (sync_due) begin
                    state_d = SYNC;
                    sh_d    = SYNC_WORD[FW-1:0];
                end else if (!q_empty) begin
                    state_d = DATA;
                    sh_d    = q_data[DATA_SIZE-1 -: FW];
                end
            end
            DATA, SYNC: begin
                // Everything holds while the FIFO is full.
                if (wr) begin
                    sh_d = sh_q >> 8;
                    if (last_byte) begin
                        state_d    = IDLE;
                        idx_d      = 2'd0;
                        sync_cnt_d = (state_q == DATA) ? sync_cnt_q + CNT_W'(1) : '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        q_count_nxt = q_count + {1'b0, q_push && (!q_full || q_pop)} - {1'b0, q_pop};
        busy_d      = (state_d != IDLE) || (q_count_nxt != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            sh_q       <= '0;
            sync_cnt_q <= CNT_W'(SYNC_PERIOD);
            drop_cnt_q <= '0;
            dropped_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            sync_cnt_q <= sync_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            dropped_q  <= drop;
            busy_q     <= busy_d;
        end
    end

endmodule
